// File: rtl/mem_stage.sv
// EX/MEM pipeline register, data-memory access FSM and MEM/WB register.
// Optional misaligned-access trap: define MEM_ALIGN_CHECK_EN.
module mem_stage #(
   parameter int XLEN  = 64,
   parameter int REG_W = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ex_valid,
   input  logic [XLEN-1:0]  ex_alu_result,
   input  logic [XLEN-1:0]  ex_store_data,
   input  logic [REG_W-1:0] ex_rd,
   input  logic             ex_reg_write,
   input  logic             ex_mem_read,
   input  logic             ex_mem_write,
   output logic             stall,
   output logic [XLEN-1:0]  mem_result,
   output logic             dmem_req,
   output logic             dmem_we,
   output logic [XLEN-1:0]  dmem_addr,
   output logic [XLEN-1:0]  dmem_wdata,
   input  logic             dmem_ready,
   input  logic             dmem_rvalid,
   input  logic [XLEN-1:0]  dmem_rdata,
   output logic             wb_valid,
   output logic [XLEN-1:0]  wb_result,
   output logic [REG_W-1:0] wb_rd,
   output logic             wb_reg_write,
   output logic             misalign_err
);

   typedef enum logic [1:0] {IDLE, ACCESS, WAIT_RD} state_e;

   state_e             state_q, state_d;
   logic               m_valid_q, m_reg_write_q, m_mem_read_q, m_mem_write_q;
   logic [XLEN-1:0]    m_alu_result_q, m_store_data_q;
   logic [REG_W-1:0]   m_rd_q;
   logic               wb_valid_q, wb_reg_write_q, misalign_q;
   logic [XLEN-1:0]    wb_result_q;
   logic [REG_W-1:0]   wb_rd_q;

   logic m_store, m_op, m_mis, ex_op, ex_mis, done_now, load_done;

   // Read+write together is treated as a load.
   assign m_store = m_mem_write_q & ~m_mem_read_q;
   assign m_op    = m_valid_q & (m_mem_read_q | m_mem_write_q);
   assign ex_op   = ex_valid & (ex_mem_read | ex_mem_write);

`ifdef MEM_ALIGN_CHECK_EN
   assign m_mis  = m_op & (m_alu_result_q[2:0] != 3'd0);
   assign ex_mis = ex_alu_result[2:0] != 3'd0;
`else
   assign m_mis  = 1'b0;
   assign ex_mis = 1'b0;
`endif

   assign done_now  = (state_q == ACCESS & m_store & dmem_ready) |
                      (state_q == WAIT_RD & dmem_rvalid);
   assign stall     = (state_q == ACCESS | state_q == WAIT_RD) & ~done_now;
   assign load_done = state_q == WAIT_RD;

   always_comb begin
      state_d = state_q;
      if (!stall)
         state_d = (ex_op & ~ex_mis) ? ACCESS : IDLE;
      else if (state_q == ACCESS && dmem_ready)
         state_d = WAIT_RD;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= IDLE;
         m_valid_q      <= 1'b0;
         m_reg_write_q  <= 1'b0;
         m_mem_read_q   <= 1'b0;
         m_mem_write_q  <= 1'b0;
         m_alu_result_q <= '0;
         m_store_data_q <= '0;
         m_rd_q         <= '0;
         wb_valid_q     <= 1'b0;
         wb_reg_write_q <= 1'b0;
         wb_result_q    <= '0;
         wb_rd_q        <= '0;
         misalign_q     <= 1'b0;
      end else begin
         state_q <= state_d;
         if (!stall) begin
            m_valid_q      <= ex_valid;
            m_reg_write_q  <= ex_valid & ex_reg_write;
            m_mem_read_q   <= ex_valid & ex_mem_read;
            m_mem_write_q  <= ex_valid & ex_mem_write;
            m_alu_result_q <= ex_alu_result;
            m_store_data_q <= ex_store_data;
            m_rd_q         <= ex_rd;
            wb_valid_q     <= m_valid_q;
            wb_result_q    <= load_done ? dmem_rdata : m_alu_result_q;
            wb_rd_q        <= m_rd_q;
            wb_reg_write_q <= m_valid_q & m_reg_write_q & ~m_store & ~m_mis;
            misalign_q     <= m_mis;
         end else begin
            wb_valid_q     <= 1'b0;
            wb_reg_write_q <= 1'b0;
            misalign_q     <= 1'b0;
         end
      end
   end

   assign mem_result   = m_alu_result_q;
   assign dmem_req     = state_q == ACCESS;
   assign dmem_we      = (state_q == ACCESS) & m_store;
   assign dmem_addr    = m_alu_result_q;
   assign dmem_wdata   = m_store_data_q;
   assign wb_valid     = wb_valid_q;
   assign wb_result    = wb_result_q;
   assign wb_rd        = wb_rd_q;
   assign wb_reg_write = wb_reg_write_q;
   assign misalign_err = misalign_q;

endmodule
